// File: rtl/lsu_dm.sv
// rtl/lsu_dm.sv - load/store unit driving a word-addressed data memory
//
// Purpose: accepts one load/store request at a time and performs it against a
// data memory whose read data is registered (one cycle behind the address).
// Sub-word stores are done as read-modify-write. Rejected requests leave the
// memory untouched and complete with err=1.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, is_store       request strobe (taken only while ready=1), direction
//   funct3              RISC-V width/sign encoding
//   addr, wdata         byte address, store data
//   ready, done, err    idle flag, one-cycle completion pulse, reject flag
//   rdata               last load result
//   dm_addr, dm_wd      data-memory word index and write data
//   dm_we, dm_rd        data-memory write enable and registered read data
module lsu_dm #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wd,
   output logic              dm_we,
   input  logic [31:0]       dm_rd
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   state_t state, next_state;

   logic              store_q;
   logic [2:0]        f3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [15:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       dm_wd_q;

   logic        f3_ok;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic        is_sw;
   logic [4:0]  byte_sh;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Request legality, evaluated on the live inputs in the accepting cycle.
   always_comb begin
      f3_ok = 1'b0;
      if (is_store)
         f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
   end

   assign misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign out_of_range = |addr[31:ADDR_W+2];
   assign req_err      = !f3_ok || misaligned || out_of_range;
   assign is_sw        = is_store && (funct3 == 3'b010);

   // Lane extraction from the registered memory word (little-endian).
   assign byte_sh   = {addr_q[1:0], 3'b000};
   assign byte_lane = dm_rd[byte_sh +: 8];
   assign half_lane = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];

   always_comb begin
      load_val = dm_rd;
      case (f3_q)
         3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_val = {24'd0, byte_lane};
         3'b101:  load_val = {16'd0, half_lane};
         default: load_val = dm_rd;
      endcase
   end

   // Read-modify-write merge; only consulted for SB/SH in CAP.
   always_comb begin
      merged = dm_rd;
      if (f3_q[1:0] == 2'b00)
         merged[byte_sh +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      done       = 1'b0;
      dm_we      = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (req) begin
               if (req_err)
                  next_state = S_DONE;
               else if (is_sw)
                  next_state = S_WR;
               else
                  next_state = S_RD;
            end
         end
         S_RD:  next_state = S_CAP;
         S_CAP: next_state = store_q ? S_WR : S_DONE;
         S_WR: begin
            // A reset landing on the write cycle must not corrupt memory.
            dm_we      = !rst;
            next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         store_q <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 16'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         dm_wd_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  store_q <= is_store;
                  f3_q    <= funct3;
                  addr_q  <= addr[ADDR_W+1:0];
                  wdata_q <= wdata[15:0];
                  err_q   <= req_err;
                  if (is_sw)
                     dm_wd_q <= wdata;
               end
            end
            S_CAP: begin
               if (store_q)
                  dm_wd_q <= merged;
               else
                  rdata_q <= load_val;
            end
            S_DONE: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign err     = err_q;
   assign rdata   = rdata_q;
   assign dm_wd   = dm_wd_q;
   assign dm_addr = addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_lsu_dm.sv
// tb/tb_lsu_dm.sv - scoreboard bench for lsu_dm with a byte-array reference model
module tb_lsu_dm;
   localparam int ADDR_W = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0] dm_wd;
   logic        dm_we;
   logic [31:0] dm_rd;

   lsu_dm #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
      .rdata(rdata), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
   );

   always #5 clk = ~clk;

   // Data memory environment: registered read port.
   logic [31:0] mem [0:31];
   always @(posedge clk) begin
      if (dm_we) mem[dm_addr] <= dm_wd;
      dm_rd <= mem[dm_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state.
   int unsigned refb [0:127];
   logic [31:0] ref_rdata;

   typedef struct { int when; logic e; logic [31:0] rd; } done_t;
   typedef struct { int when; logic [4:0] idx; logic [31:0] data; } wr_t;
   done_t dq[$];
   wr_t   wq[$];

   int checks = 0;
   int failures = 0;
   bit mon_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares completions and memory writes against queued expectations.
   done_t md;
   wr_t   mw;
   always @(negedge clk) begin
      if (mon_en) begin
         if (done !== 1'b0) begin
            if (dq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=%b expected=0 t=%0t", done, $time);
            end else begin
               md = dq.pop_front();
               check("done_cycle", cyc, md.when);
               check("err", {31'd0, err}, {31'd0, md.e});
               check("rdata", rdata, md.rd);
            end
         end
         if (dm_we !== 1'b0) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write actual=%b expected=0 idx=%0d t=%0t", dm_we, dm_addr, $time);
            end else begin
               mw = wq.pop_front();
               check("write_cycle", cyc, mw.when);
               check("write_idx", {27'd0, dm_addr}, {27'd0, mw.idx});
               check("write_data", dm_wd, mw.data);
            end
         end
      end
   end

   task automatic garbage();
      is_store = 1'($urandom);
      funct3   = 3'($urandom);
      addr     = $urandom;
      wdata    = $urandom;
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      ok = 1;
      while (ready !== 1'b1) begin
         if (n > 50) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=%b expected=1", ready);
            ok = 0;
            return;
         end
         req = 1'($urandom_range(0, 1));
         garbage();
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Issue one request and push what the model says must come out of it.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      bit ok;
      int unsigned size, v, w;
      bit legal, bad;
      done_t d;
      wr_t   wr;
      wait_ready(ok);
      if (!ok) return;
      req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      size  = 1 << f3[1:0];
      legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      bad   = !legal || ((a % size) != 0) || (a > 127);
      if (bad) begin
         d.when = cyc + 1; d.e = 1'b1; d.rd = ref_rdata;
      end else if (!st) begin
         v = 0;
         for (int i = 0; i < int'(size); i++) v = v + refb[a + i] * (1 << (8 * i));
         if (f3 == 3'b000 && v >= 128)   v = v - 256;
         if (f3 == 3'b001 && v >= 32768) v = v - 65536;
         ref_rdata = v;
         d.when = cyc + 3; d.e = 1'b0; d.rd = ref_rdata;
      end else begin
         for (int i = 0; i < int'(size); i++) refb[a + i] = (wd >> (8 * i)) % 256;
         w = 0;
         for (int i = 0; i < 4; i++) w = w + refb[(a / 4) * 4 + i] * (1 << (8 * i));
         wr.when = cyc + ((size == 4) ? 1 : 3);
         wr.idx  = 5'(a / 4);
         wr.data = w;
         wq.push_back(wr);
         d.when = cyc + ((size == 4) ? 2 : 4); d.e = 1'b0; d.rd = ref_rdata;
      end
      dq.push_back(d);
      @(posedge clk); #1;
      req = 1'b0;
      garbage();
   endtask

   initial begin
      bit ok;
      int r;
      logic [2:0] f3;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      for (int i = 0; i < 128; i++) refb[i] = 0;
      ref_rdata = 32'd0;
      rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_done",  {31'd0, done},  32'd0);
      check("reset_err",   {31'd0, err},   32'd0);
      check("reset_dm_we", {31'd0, dm_we}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_dm_wd", dm_wd, 32'd0);
      check("reset_dm_addr", {27'd0, dm_addr}, 32'd0);
      mon_en = 1;

      issue(1, 3'b010, 32'h08, 32'h8899AABB);
      issue(0, 3'b010, 32'h08, 32'h0);
      issue(0, 3'b000, 32'h0B, 32'h0);
      issue(0, 3'b100, 32'h0B, 32'h0);
      issue(0, 3'b001, 32'h0A, 32'h0);
      issue(0, 3'b101, 32'h08, 32'h0);
      issue(1, 3'b000, 32'h09, 32'h123456CC);
      issue(0, 3'b010, 32'h08, 32'h0);
      issue(1, 3'b001, 32'h0A, 32'h00007F01);
      issue(0, 3'b010, 32'h08, 32'h0);
      issue(0, 3'b010, 32'h06, 32'h0);
      issue(0, 3'b001, 32'h03, 32'h0);
      issue(0, 3'b010, 32'h80, 32'h0);
      issue(1, 3'b100, 32'h08, 32'h11111111);

      // SB aborted by reset during its write cycle: no write, no done.
      wait_ready(ok);
      if (ok) begin
         req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h08; wdata = 32'h000000EE;
         @(posedge clk); #1;
         req = 1'b0;
         @(posedge clk);
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         ref_rdata = 32'd0;
         @(negedge clk);
         check("abort_ready", {31'd0, ready}, 32'd1);
         check("abort_rdata", rdata, 32'd0);
      end
      issue(0, 3'b010, 32'h08, 32'h0);

      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         r  = $urandom_range(0, 9);
         if (r == 0)      a = $urandom;
         else if (r < 7)  a = $urandom_range(0, 127) & ~((32'd1 << f3[1:0]) - 1);
         else             a = $urandom_range(0, 127);
         issue(1'($urandom), f3, a, $urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      for (int n = 0; n < 50 && (dq.size() != 0 || wq.size() != 0); n++) @(posedge clk);
      #1;
      check("pending_done",  dq.size(), 32'd0);
      check("pending_write", wq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_dm.md
# lsu_dm

Load/store unit for the RISC-V core's data path. It accepts one load or store request at a time from the execute stage and drives the 32x32 word-addressed data memory port. It handles the byte and halfword encodings LB/LH/LW/LBU/LHU and SB/SH/SW:
- loads are sign- or zero-extended;
- sub-word stores use read-modify-write;
- misaligned, out-of-range or illegal accesses are rejected with an error flag.

## Interface
Parameters:
- ADDR_W, 5, data-memory word-address width. Valid byte addresses are 0 .. 4*2^ADDR_W-1.

Ports:
- clk  in  1  single clock; everything updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request strobe; accepted only when ready=1.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = access rejected, memory untouched.
- rdata  out  32  load result; valid from the done cycle until the next accepted load.
- dm_addr  out  ADDR_W  word index to data memory (addr[ADDR_W+1:2] of the latched request).
- dm_wd  out  32  write data to data memory.
- dm_we  out  1  write enable to data memory.
- dm_rd  in  32  data memory read data. It is registered in memory: it reflects the word addressed in the previous cycle.

## Operation
FSM states and transitions:
- IDLE: ready=1. On req, latch is_store, funct3, addr and wdata, then check the request:
  - err when funct3 is illegal for the direction;
  - err when a halfword access has addr[0]≠0;
  - err when a word access has addr[1:0]≠0;
  - err when addr[31:ADDR_W+2]≠0.
  - Next state:
    - error → DONE with err=1;
    - SW → WR;
    - any load, SB or SH → RD.
- RD: dm_addr = word index, dm_we=0. Next state is CAP.
- CAP: dm_rd now holds the addressed word.
  - Load: extract the lane selected by addr[1:0] (little-endian), extend it, register it into rdata, then go to DONE.
  - SB/SH: merge wdata[7:0] or wdata[15:0] into the lane of dm_rd and register the result as dm_wd, then go to WR.
- WR: dm_we = 1 & !rst; dm_wd is the merged word (SW: wdata). Next state is DONE.
- DONE: done=1 and ready=0. Next state is IDLE.

Rules:
- Lane select for halfwords is addr[1] only.
- Sign extension copies bit 7 (LB) or bit 15 (LH). LBU/LHU zero-fill.
- rdata is unchanged by stores and errors.
- req is ignored whenever ready=0. Input changes after acceptance have no effect.
- Memory is never written on an error or on a load.

## Timing
Let cycle A be the cycle in which req=1 and ready=1 are sampled.

Latency:
- Load: RD at A+1, CAP at A+2, done at A+3.
- SW: WR at A+1, done at A+2.
- SB/SH: RD at A+1, CAP at A+2, WR at A+3, done at A+4.
- Error: done with err=1 at A+1.
- Back-to-back: the next request is accepted at the earliest in the cycle after done (ready returns in IDLE).

Reset:
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, dm_addr=0, dm_wd=0, dm_we=0.
- rst sampled high in any state → IDLE next cycle.
- dm_we is gated by rst, so a WR cycle coinciding with rst does not write.
- No done is produced for an aborted request.
- err is cleared when leaving DONE.

## Test plan
- Reset release → ready=1, done=0, dm_we=0, rdata=0.
- SW addr=0x08 wdata=0x8899AABB → dm_we=1 with dm_addr=2 at A+1, done at A+2. Then LW 0x08 → rdata=0x8899AABB, done at A+3.
- Following the above, loads with done at A+3:
  - LB 0x0B → rdata=0xFFFFFF88;
  - LBU 0x0B → 0x00000088;
  - LH 0x0A → 0xFFFF8899;
  - LHU 0x08 → 0x0000AABB.
- SB addr=0x09 wdata=0x123456CC → write at A+3 of 0x8899CCBB, done at A+4. Then SH 0x0A wdata=0x00007F01 → word=0x7F01CCBB.
- Each of the following → err=1 with done at A+1, no dm_we pulse, rdata unchanged:
  - LW 0x06;
  - LH 0x03;
  - LW 0x80 (ADDR_W=5);
  - store funct3=100.
- SB 0x08 with rst asserted during its WR cycle → dm_we stays 0, no done, ready=1 next cycle. Word 2 still reads 0x7F01CCBB.
